// File: rtl/sobel_pkg.sv
// Shared definitions for the grayscale -> 3x3 window -> Sobel pipeline.
package sobel_pkg;

  localparam int DATA_W     = 8;
  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;
  localparam int NUM_TAPS   = 9;

  // Tap k = 3*r + c; r=0 is the oldest row, c=0 the oldest column.
  localparam int TAP_TL = 0;
  localparam int TAP_T  = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_L  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_R  = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_B  = 7;
  localparam int TAP_BR = 8;

  typedef logic [NUM_TAPS-1:0][DATA_W-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port, read-first line buffer: the read returns the value stored
// before any write in the same cycle.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Asynchronous read of the stored word gives old data when we is high.
  assign rd_data = mem[addr];

  // Store the new word on write.
  // NOTE: the array has no reset; stale contents are never observed because
  // the top only declares a window once two fresh rows have been written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift
// window, row/column tracking, start-of-frame resync and frame-done pulse.
module gray_window_3x3 #(
  parameter int DATA_W     = sobel_pkg::DATA_W,
  parameter int IMG_WIDTH  = sobel_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = sobel_pkg::IMG_HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   pix_i,
  input  logic                pix_valid_i,
  input  logic                sof_i,
  output logic [9*DATA_W-1:0] win_o,
  output logic                win_valid_o,
  output logic                frame_done_o
);

  import sobel_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col, acc_col;
  logic [RW-1:0] row, acc_row;
  logic          last_col, last_row, accept;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [NUM_TAPS-1:0][DATA_W-1:0] win_q;

  // Position of the pixel being accepted; start-of-frame forces (0,0).
  // NOTE: always_comb with every output assigned on every path keeps this
  // purely combinational; no latch can be inferred.
  always_comb begin
    accept   = rst && pix_valid_i;
    acc_col  = sof_i ? '0 : col;
    acc_row  = sof_i ? '0 : row;
    last_col = (acc_col == CW'(IMG_WIDTH - 1));
    last_row = (acc_row == RW'(IMG_HEIGHT - 1));
  end

  // lb0 holds the previous row, lb1 the row before it; lb1 takes lb0's old word.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (acc_col),
    .wr_data (pix_i),
    .rd_data (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (acc_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Counters, window shift and registered status flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees pre-edge values (the shift works in place).
  always_ff @(posedge clk) begin
    if (!rst) begin
      row          <= '0;
      col          <= '0;
      win_q        <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      if (pix_valid_i) begin
        win_q[TAP_TL] <= win_q[TAP_T];
        win_q[TAP_T]  <= win_q[TAP_TR];
        win_q[TAP_TR] <= lb1_rd;
        win_q[TAP_L]  <= win_q[TAP_C];
        win_q[TAP_C]  <= win_q[TAP_R];
        win_q[TAP_R]  <= lb0_rd;
        win_q[TAP_BL] <= win_q[TAP_B];
        win_q[TAP_B]  <= win_q[TAP_BR];
        win_q[TAP_BR] <= pix_i;

        win_valid_o  <= (acc_row >= RW'(2)) && (acc_col >= CW'(2));
        frame_done_o <= last_row && last_col;

        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : acc_row + RW'(1);
        end else begin
          col <= acc_col + CW'(1);
          row <= acc_row;
        end
      end
    end
  end

  assign win_o = win_q;

endmodule
